gpio_pad_ctrl: RTL and testbench
================================

// Module: gpio_pad_ctrl
//
// PURPOSE
// - Core-side end of the bidirectional pad wrappers: drives pad_ena/to_pad, consumes from_pad.
// - Per-bit direction, output and open-drain control; 2-flop input synchroniser; debounce; edge detect.
// - Sticky edge status and a level IRQ; programmed over a simple single-cycle register bus from the CPU.
//
// PARAMETERS
// - NR_GPIOS         8   number of pad bits, 1..32
// - DEBOUNCE_CYCLES  16  consecutive stable cycles before the debounced input changes; 0 = bypass
//
// PORTS
// - clk            in   1         system clock; everything on the rising edge
// - reset_         in   1         asynchronous, active-low reset
// - req_valid      in   1         register access request; always accepted, no backpressure
// - req_wr         in   1         1 = write, 0 = read
// - req_addr       in   5         byte address; bits [1:0] ignored
// - req_wdata      in   32        write data; bits >= NR_GPIOS ignored
// - rsp_valid      out  1         read data valid, exactly 1 cycle after a read request
// - rsp_rdata      out  32        read data; bits >= NR_GPIOS read 0
// - pad_ena        out  NR_GPIOS  per-bit output enable to the pad_inout instances
// - to_pad         out  NR_GPIOS  per-bit output value to the pad_inout instances
// - from_pad       in   NR_GPIOS  per-bit raw pad input, asynchronous to clk
// - irq            out  1         |(IRQ_STATUS), registered
//
// BEHAVIOUR
// - Register map:
//   - 0x00 DIR: 1 = output
//   - 0x04 OUT
//   - 0x08 IN: read-only, debounced value
//   - 0x0C OD: 1 = open-drain
//   - 0x10 RISE_EN
//   - 0x14 FALL_EN
//   - 0x18 IRQ_STATUS: read, write-1-to-clear
//   - 0x1C: reads 0, writes ignored
// - Reset:
//   - All registers are 0; pad_ena=0, to_pad=0, rsp_valid=0, rsp_rdata=0, irq=0.
//   - Sync flops and debounced value are 0; debounce counters are 0.
// - Output drive, combinational from registers:
//   - OD=0: pad_ena = DIR, to_pad = OUT.
//   - OD=1: pad_ena = DIR & ~OUT, to_pad = 0 (drive low only; release when OUT=1).
// - Writes take effect on the clock edge of the request; pad_ena/to_pad change the next cycle.
// - Reads are registered:
//   - rsp_valid=1 and rsp_rdata are valid on the cycle after req_valid & ~req_wr.
//   - Otherwise rsp_valid=0 and rsp_rdata holds its last value.
// - Input synchroniser: s1 <= from_pad, s2 <= s1. s2 is the only input path; nothing else samples from_pad.
// - Debounce, per bit:
//   - If s2 == deb: cnt <= 0.
//   - Else if cnt == DEBOUNCE_CYCLES-1: deb <= s2, cnt <= 0.
//   - Else: cnt <= cnt+1.
//   - Any glitch shorter than DEBOUNCE_CYCLES is rejected.
//   - DEBOUNCE_CYCLES=0: deb <= s2 every cycle.
// - Latency, pad step to IN readable: 2 + max(DEBOUNCE_CYCLES,1) cycles.
// - Edges are evaluated on the cycle deb updates:
//   - rise = ~deb & deb_next
//   - fall = deb & ~deb_next
// - IRQ_STATUS next state = (STATUS & ~w1c_mask) | (rise & RISE_EN) | (fall & FALL_EN).
//   - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
// - irq is registered: it asserts 1 cycle after STATUS becomes non-zero and deasserts 1 cycle after it clears.
// - Disabling RISE_EN/FALL_EN does not clear STATUS bits that are already set.
// - The input path runs regardless of DIR, so output bits read back their own pad level.
// - Reset asserted mid-debounce or mid-read: all state clears immediately and any pending rsp_valid is dropped.
//
// STRUCTURE
// - gpio_pkg.vh holds the shared constants:
//   - register offsets GPIO_DIR .. GPIO_IRQ_STATUS
//   - GPIO_ADDR_W=5
// - Sub-module gpio_debounce: one bit; contains the synchroniser, counter and deb flop, and outputs deb/rise/fall.
//   - Instantiated NR_GPIOS times with a generate loop.
// - Counter width = $clog2(DEBOUNCE_CYCLES+1), with a minimum of 1.
// - The top level holds the register file, read mux, drive logic, IRQ_STATUS and irq.
//
// TESTING
// 1. Reset, then read all offsets: every read returns 0, pad_ena=0, irq=0; read 0x1C returns 0.
// 2. Write DIR=0x0F, OUT=0x05: pad_ena=0x0F, to_pad=0x05 one cycle later.
//    Then OD=0x01, OUT=0x01: pad_ena[0]=0. Then OUT=0x00: pad_ena[0]=1, to_pad[0]=0.
// 3. DEBOUNCE_CYCLES=16: pulse from_pad[3] high for 15 cycles -> IN[3] stays 0, no status.
//    Hold it high -> IN[3]=1 exactly 18 cycles after the step.
// 4. RISE_EN=0x08, raise from_pad[3] -> IRQ_STATUS=0x08, irq=1 one cycle later.
//    Write 0x08 to 0x18 -> status 0, irq=0. A fall with FALL_EN=0 -> no status.
// 5. Arrange a rise on bit 3 in the same cycle as a W1C of bit 3 -> bit 3 stays set.
// 6. Hold from_pad high and assert reset_ mid-debounce -> all outputs 0 immediately.
//    After release, IN[3] reaches 1 a full 18 cycles later.

Source files
------------

// File: rtl/gpio_pad_ctrl_pkg.sv
// Shared register map and address helpers for the GPIO pad controller.
// Offsets are byte addresses; the low two address bits never select a register.
package gpio_pad_ctrl_pkg;

    localparam int GPIO_ADDR_W = 5;

    typedef enum logic [GPIO_ADDR_W-1:0] {
        GPIO_DIR        = 5'h00,
        GPIO_OUT        = 5'h04,
        GPIO_IN         = 5'h08,
        GPIO_OD         = 5'h0C,
        GPIO_RISE_EN    = 5'h10,
        GPIO_FALL_EN    = 5'h14,
        GPIO_IRQ_STATUS = 5'h18,
        GPIO_RSVD       = 5'h1C
    } gpio_reg_e;

    function automatic logic [GPIO_ADDR_W-1:0] word_addr(input logic [GPIO_ADDR_W-1:0] addr);
        return {addr[GPIO_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/gpio_pad_ctrl_debounce.sv
// One pad bit: 2-flop synchroniser, stability counter and debounced level.
// rise/fall are combinational and valid in the cycle the debounced level updates.
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_,
    input  logic pad_in,
    output logic deb,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic s1;
    logic s2;
    logic deb_next;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            deb <= 1'b0;
        end else begin
            s1  <= pad_in;
            s2  <= s1;
            deb <= deb_next;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign deb_next = s2;
        end else begin : g_count
            localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt;
            logic [CNT_W-1:0] cnt_next;

            // Any disagreement with the current level must persist for the full window.
            always_comb begin
                cnt_next = '0;
                deb_next = deb;
                if (s2 != deb) begin
                    if (cnt == CNT_MAX) begin
                        deb_next = s2;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_) begin
                if (!reset_) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt_next;
                end
            end
        end
    endgenerate

    assign rise = ~deb & deb_next;
    assign fall = deb & ~deb_next;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// Core-side GPIO controller: register file, pad drive, debounced inputs,
// sticky edge status and a registered level interrupt.
module gpio_pad_ctrl
    import gpio_pad_ctrl_pkg::*;
#(
    parameter int NR_GPIOS        = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic                   req_valid,
    input  logic                   req_wr,
    input  logic [GPIO_ADDR_W-1:0] req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic [NR_GPIOS-1:0]    pad_ena,
    output logic [NR_GPIOS-1:0]    to_pad,
    input  logic [NR_GPIOS-1:0]    from_pad,
    output logic                   irq
);

    logic [NR_GPIOS-1:0] dir_q;
    logic [NR_GPIOS-1:0] out_q;
    logic [NR_GPIOS-1:0] od_q;
    logic [NR_GPIOS-1:0] rise_en_q;
    logic [NR_GPIOS-1:0] fall_en_q;
    logic [NR_GPIOS-1:0] status_q;
    logic [NR_GPIOS-1:0] status_next;
    logic [NR_GPIOS-1:0] w1c_mask;
    logic [NR_GPIOS-1:0] deb;
    logic [NR_GPIOS-1:0] rise;
    logic [NR_GPIOS-1:0] fall;
    logic [NR_GPIOS-1:0] wdata;
    logic [NR_GPIOS-1:0] rd_bits;
    logic [GPIO_ADDR_W-1:0] addr_w;
    logic wr_en;
    logic rd_en;
    logic unused_ok;

    assign addr_w    = word_addr(req_addr);
    assign wdata     = req_wdata[NR_GPIOS-1:0];
    assign wr_en     = req_valid & req_wr;
    assign rd_en     = req_valid & ~req_wr;
    assign unused_ok = ^{req_addr[1:0], req_wdata};

    for (genvar g = 0; g < NR_GPIOS; g++) begin : g_bit
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset_ (reset_),
            .pad_in (from_pad[g]),
            .deb    (deb[g]),
            .rise   (rise[g]),
            .fall   (fall[g])
        );
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            dir_q     <= '0;
            out_q     <= '0;
            od_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else if (wr_en) begin
            case (addr_w)
                GPIO_DIR:     dir_q     <= wdata;
                GPIO_OUT:     out_q     <= wdata;
                GPIO_OD:      od_q      <= wdata;
                GPIO_RISE_EN: rise_en_q <= wdata;
                GPIO_FALL_EN: fall_en_q <= wdata;
                default:      ;
            endcase
        end
    end

    // Open-drain bits only ever pull low: release the pad when OUT is high.
    assign pad_ena = dir_q & ~(od_q & out_q);
    assign to_pad  = out_q & ~od_q;

    // New edge events are OR-ed in after the clear so a same-cycle set wins.
    assign w1c_mask    = (wr_en && addr_w == GPIO_IRQ_STATUS) ? wdata : '0;
    assign status_next = (status_q & ~w1c_mask) | (rise & rise_en_q) | (fall & fall_en_q);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            status_q <= '0;
            irq      <= 1'b0;
        end else begin
            status_q <= status_next;
            irq      <= |status_q;
        end
    end

    always_comb begin
        rd_bits = '0;
        case (addr_w)
            GPIO_DIR:        rd_bits = dir_q;
            GPIO_OUT:        rd_bits = out_q;
            GPIO_IN:         rd_bits = deb;
            GPIO_OD:         rd_bits = od_q;
            GPIO_RISE_EN:    rd_bits = rise_en_q;
            GPIO_FALL_EN:    rd_bits = fall_en_q;
            GPIO_IRQ_STATUS: rd_bits = status_q;
            default:         rd_bits = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= rd_en;
            if (rd_en) begin
                rsp_rdata <= 32'(rd_bits);
            end
        end
    end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed bench for gpio_pad_ctrl: reads are scored through a queue drained by a monitor,
// pad/irq levels are compared directly at the points where their values are known.
module tb_gpio_pad_ctrl;
    import gpio_pad_ctrl_pkg::*;

    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          reset_ = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_wr = 1'b0;
    logic [4:0]    req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic [NR-1:0] pad_ena;
    logic [NR-1:0] to_pad;
    logic [NR-1:0] from_pad = '0;
    logic          irq;

    gpio_pad_ctrl #(
        .NR_GPIOS(NR),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk       (clk),
        .reset_    (reset_),
        .req_valid (req_valid),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .pad_ena   (pad_ena),
        .to_pad    (to_pad),
        .from_pad  (from_pad),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rsp_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rsp: got %h at cycle %0d, expected no response", rsp_rdata, cyc);
            end else begin
                e = sb.pop_front();
                if (rsp_rdata !== e.data || cyc != e.due) begin
                    bad++;
                    $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
                             e.name, rsp_rdata, cyc, e.data, e.due);
                end
            end
        end else if (sb.size() != 0 && cyc >= sb[0].due) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s: no rsp_valid at cycle %0d, expected %h", e.name, cyc, e.data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        req_wr    = 1'b0;
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] want);
        exp_t e;
        e.name = name;
        e.data = want;
        e.due  = cyc + 1;
        sb.push_back(e);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = a;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pad_ena", 32'(pad_ena), 32'h0);
        chk("rst_to_pad", 32'(to_pad), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        reset_ = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) rd("rst_read", 5'(i * 4), 32'h0);

        // Output drive, push-pull then open-drain
        wr(GPIO_DIR, 32'hFFFF_FF0F);
        wr(GPIO_OUT, 32'h0000_0005);
        chk("pp_pad_ena", 32'(pad_ena), 32'h0F);
        chk("pp_to_pad", 32'(to_pad), 32'h05);
        rd("dir_readback", GPIO_DIR, 32'h0F);
        rd("out_readback_lowbits", 5'h07, 32'h05);
        wr(GPIO_OD, 32'h01);
        wr(GPIO_OUT, 32'h01);
        chk("od_release_pad_ena", 32'(pad_ena), 32'h0E);
        chk("od_release_to_pad", 32'(to_pad), 32'h00);
        wr(GPIO_OUT, 32'h00);
        chk("od_drive_pad_ena", 32'(pad_ena), 32'h0F);
        chk("od_drive_to_pad", 32'(to_pad), 32'h00);
        rd("od_readback", GPIO_OD, 32'h01);
        wr(GPIO_RSVD, 32'hFFFF_FFFF);
        rd("rsvd_read", GPIO_RSVD, 32'h0);

        // 15-cycle glitch is rejected even with rise enabled
        wr(GPIO_RISE_EN, 32'h08);
        from_pad[3] = 1'b1;
        repeat (15) @(negedge clk);
        from_pad[3] = 1'b0;
        repeat (25) @(negedge clk);
        rd("glitch_in", GPIO_IN, 32'h0);
        rd("glitch_status", GPIO_IRQ_STATUS, 32'h0);
        chk("glitch_irq", 32'(irq), 32'h0);

        // Step: IN flips on the 18th edge, irq one cycle after status
        from_pad[3] = 1'b1;
        repeat (17) @(negedge clk);
        rd("step_in_edge18", GPIO_IN, 32'h0);
        chk("step_irq_edge18", 32'(irq), 32'h0);
        rd("step_in_edge19", GPIO_IN, 32'h08);
        chk("step_irq_edge19", 32'(irq), 32'h1);
        rd("rise_status", GPIO_IRQ_STATUS, 32'h08);
        wr(GPIO_IRQ_STATUS, 32'h08);
        chk("w1c_irq_lag", 32'(irq), 32'h1);
        @(negedge clk);
        chk("w1c_irq_clear", 32'(irq), 32'h0);
        rd("w1c_status", GPIO_IRQ_STATUS, 32'h0);

        // Fall without FALL_EN: no status
        from_pad[3] = 1'b0;
        repeat (25) @(negedge clk);
        rd("fall_in", GPIO_IN, 32'h0);
        rd("fall_dis_status", GPIO_IRQ_STATUS, 32'h0);
        chk("fall_dis_irq", 32'(irq), 32'h0);

        // Rise lands on the same edge as a W1C of the same bit
        from_pad[3] = 1'b1;
        repeat (17) @(negedge clk);
        wr(GPIO_IRQ_STATUS, 32'h08);
        rd("set_wins_status", GPIO_IRQ_STATUS, 32'h08);
        wr(GPIO_IRQ_STATUS, 32'h08);
        rd("set_wins_cleared", GPIO_IRQ_STATUS, 32'h0);

        // Fall with FALL_EN, then disabling the enable keeps the bit
        wr(GPIO_FALL_EN, 32'h08);
        from_pad[3] = 1'b0;
        repeat (22) @(negedge clk);
        rd("fall_en_status", GPIO_IRQ_STATUS, 32'h08);
        chk("fall_en_irq", 32'(irq), 32'h1);
        wr(GPIO_FALL_EN, 32'h00);
        rd("fall_sticky_status", GPIO_IRQ_STATUS, 32'h08);

        // Reset mid-debounce and mid-read
        from_pad[3] = 1'b1;
        repeat (8) @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = GPIO_DIR;
        @(posedge clk);
        #2;
        reset_    = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("arst_rsp_rdata", rsp_rdata, 32'h0);
        chk("arst_pad_ena", 32'(pad_ena), 32'h0);
        chk("arst_to_pad", 32'(to_pad), 32'h0);
        chk("arst_irq", 32'(irq), 32'h0);
        repeat (3) @(negedge clk);
        reset_ = 1'b1;
        repeat (17) @(negedge clk);
        rd("post_rst_in_edge18", GPIO_IN, 32'h0);
        rd("post_rst_in_edge19", GPIO_IN, 32'h08);
        rd("post_rst_dir", GPIO_DIR, 32'h0);
        rd("post_rst_status", GPIO_IRQ_STATUS, 32'h0);

        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
